// File: rtl/nco_cfg_sched_if.sv
// NCO scheduler bus: control pulses, loop-filter and host write requests,
// and the registered NCO programming port.
interface nco_cfg_sched_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              stop;
    logic              lf_valid;
    logic [DATA_W-1:0] lf_data;
    logic              host_req;
    logic              host_sel;
    logic [DATA_W-1:0] host_data;
    logic              host_ack;
    logic              nco_we;
    logic              nco_reg_sel;
    logic [DATA_W-1:0] nco_data;
    logic              nco_ce;
    logic              nco_sclr;
    logic              running;
    logic [15:0]       lf_drop_cnt;

    modport master (
        output start, stop, lf_valid, lf_data, host_req, host_sel, host_data,
        input  host_ack, nco_we, nco_reg_sel, nco_data, nco_ce, nco_sclr,
               running, lf_drop_cnt
    );

    modport slave (
        input  start, stop, lf_valid, lf_data, host_req, host_sel, host_data,
        output host_ack, nco_we, nco_reg_sel, nco_data, nco_ce, nco_sclr,
               running, lf_drop_cnt
    );
endinterface

// File: rtl/nco_cfg_sched.sv
// NCO programming-port owner: init sequence (freq, phase, clear), then RUN-time
// sharing of the write port between host reprograms and loop-filter updates.
module nco_cfg_sched #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] FREQ_INIT  = 32'h2000_0000,
    parameter logic [DATA_W-1:0] PHASE_INIT = 32'h9000_0000,
    parameter int                WR_GAP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    nco_cfg_sched_if.slave    bus
);
    localparam logic [3:0] GAP_LD = 4'(WR_GAP);

    typedef enum logic [2:0] {
        IDLE, WR_FREQ, GAP_F, WR_PHASE, GAP_P, CLEAR, RUN
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        gap_cnt, gap_nx;
    logic              buf_full, buf_full_nx;
    logic [DATA_W-1:0] buf_data, buf_data_nx;
    logic [15:0]       drop_cnt, drop_nx;

    logic              we_q, sel_q, ce_q, sclr_q, run_q, ack_q;
    logic [DATA_W-1:0] data_q;
    logic              we_nx, sel_nx, ce_nx, sclr_nx, run_nx, ack_nx;
    logic [DATA_W-1:0] data_nx;

    // Output registers are loaded with the values of the state being entered,
    // so every output appears in the first cycle of its state.
    always_comb begin
        state_nx    = state;
        gap_nx      = (gap_cnt != 4'd0) ? gap_cnt - 4'd1 : gap_cnt;
        buf_full_nx = buf_full;
        buf_data_nx = buf_data;
        drop_nx     = drop_cnt;
        we_nx       = 1'b0;
        sel_nx      = sel_q;
        data_nx     = data_q;
        ce_nx       = 1'b0;
        sclr_nx     = 1'b0;
        run_nx      = 1'b0;
        ack_nx      = 1'b0;

        if (state != IDLE && bus.stop) begin
            state_nx    = IDLE;
            buf_full_nx = 1'b0;
            sel_nx      = 1'b0;
            data_nx     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = WR_FREQ;
                        we_nx    = 1'b1;
                        sel_nx   = 1'b0;
                        data_nx  = FREQ_INIT;
                        gap_nx   = GAP_LD;
                    end
                end
                WR_FREQ:  state_nx = GAP_F;
                GAP_F: begin
                    if (gap_cnt == 4'd0) begin
                        state_nx = WR_PHASE;
                        we_nx    = 1'b1;
                        sel_nx   = 1'b1;
                        data_nx  = PHASE_INIT;
                        gap_nx   = GAP_LD;
                    end
                end
                WR_PHASE: state_nx = GAP_P;
                GAP_P: begin
                    if (gap_cnt == 4'd0) begin
                        state_nx = CLEAR;
                        ce_nx    = 1'b1;
                        sclr_nx  = 1'b1;
                    end
                end
                CLEAR: begin
                    state_nx = RUN;
                    ce_nx    = 1'b1;
                    run_nx   = 1'b1;
                end
                RUN: begin
                    ce_nx  = 1'b1;
                    run_nx = 1'b1;
                    if (gap_cnt == 4'd0 && bus.host_req) begin
                        we_nx   = 1'b1;
                        sel_nx  = bus.host_sel;
                        data_nx = bus.host_data;
                        ack_nx  = 1'b1;
                        gap_nx  = GAP_LD;
                    end else if (gap_cnt == 4'd0 && buf_full) begin
                        we_nx       = 1'b1;
                        sel_nx      = 1'b0;
                        data_nx     = buf_data;
                        buf_full_nx = 1'b0;
                        gap_nx      = GAP_LD;
                    end
                    // A drain this cycle has already emptied buf_full_nx, so the
                    // new word then lands without counting a drop.
                    if (bus.lf_valid) begin
                        if (buf_full_nx && drop_cnt != 16'hFFFF)
                            drop_nx = drop_cnt + 16'd1;
                        buf_full_nx = 1'b1;
                        buf_data_nx = bus.lf_data;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= 4'd0;
            buf_full <= 1'b0;
            buf_data <= '0;
            drop_cnt <= 16'd0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            data_q   <= '0;
            ce_q     <= 1'b0;
            sclr_q   <= 1'b0;
            run_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            buf_full <= buf_full_nx;
            buf_data <= buf_data_nx;
            drop_cnt <= drop_nx;
            we_q     <= we_nx;
            sel_q    <= sel_nx;
            data_q   <= data_nx;
            ce_q     <= ce_nx;
            sclr_q   <= sclr_nx;
            run_q    <= run_nx;
            ack_q    <= ack_nx;
        end
    end

    assign bus.nco_we      = we_q;
    assign bus.nco_reg_sel = sel_q;
    assign bus.nco_data    = data_q;
    assign bus.nco_ce      = ce_q;
    assign bus.nco_sclr    = sclr_q;
    assign bus.running     = run_q;
    assign bus.host_ack    = ack_q;
    assign bus.lf_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_nco_cfg_sched.sv
// Bench for nco_cfg_sched: init/LF vector table, directed corner sequences and
// random traffic, all checked every cycle against a timeline-based reference model.
module tb_nco_cfg_sched;
    localparam int          DW = 32;
    localparam logic [31:0] FI = 32'h2000_0000;
    localparam logic [31:0] PI = 32'h9000_0000;
    localparam int          G  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nco_cfg_sched_if #(.DATA_W(DW)) bus();

    nco_cfg_sched #(.DATA_W(DW), .FREQ_INIT(FI), .PHASE_INIT(PI), .WR_GAP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        we;
        logic        sel;
        logic [31:0] data;
        logic        ce;
        logic        sclr;
        logic        run;
        logic        ack;
        logic [15:0] drop;
    } outs_t;

    typedef struct {
        logic        start;
        logic        lfv;
        logic [31:0] lfd;
        logic        we;
        logic        sel;
        logic [31:0] data;
        logic        ce;
        logic        sclr;
        logic        run;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: init is a fixed timeline counted from the start edge,
    // RUN spacing is judged from the cycle of the previous write.
    outs_t       m;
    int          m_mode;   // 0 idle, 1 init, 2 run
    int          m_t;
    longint      cyc     = 0;
    longint      last_wr = -100;
    longint      last_we = -1;
    logic        m_full;
    logic [31:0] m_buf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = {bus.nco_we, bus.nco_reg_sel, bus.nco_data, bus.nco_ce, bus.nco_sclr,
             bus.running, bus.host_ack, bus.lf_drop_cnt};
        return o;
    endfunction

    function automatic void wr(input logic s, input logic [31:0] d);
        m.we    = 1'b1;
        m.sel   = s;
        m.data  = d;
        last_wr = cyc;
    endfunction

    function automatic void model_edge();
        cyc++;
        m.we   = 1'b0;
        m.ack  = 1'b0;
        m.sclr = 1'b0;
        if (rst) begin
            m       = '0;
            m_mode  = 0;
            m_full  = 1'b0;
            last_wr = -100;
        end else if (m_mode != 0 && bus.stop) begin
            m_mode = 0;
            m.ce   = 1'b0;
            m.run  = 1'b0;
            m.sel  = 1'b0;
            m.data = '0;
            m_full = 1'b0;
        end else begin
            case (m_mode)
                0: if (bus.start && !bus.stop) begin
                    m_mode = 1;
                    m_t    = 0;
                    wr(1'b0, FI);
                end
                1: begin
                    m_t++;
                    if (m_t == 1 + G) wr(1'b1, PI);
                    else if (m_t == 2*G + 2) begin m.sclr = 1'b1; m.ce = 1'b1; end
                    else if (m_t == 2*G + 3) begin m_mode = 2; m.ce = 1'b1; m.run = 1'b1; end
                end
                default: begin
                    if (cyc - last_wr >= G + 1 && bus.host_req) begin
                        wr(bus.host_sel, bus.host_data);
                        m.ack = 1'b1;
                    end else if (cyc - last_wr >= G + 1 && m_full) begin
                        wr(1'b0, m_buf);
                        m_full = 1'b0;
                    end
                    if (bus.lf_valid) begin
                        if (m_full && m.drop != 16'hFFFF) m.drop = m.drop + 16'd1;
                        m_full = 1'b1;
                        m_buf  = bus.lf_data;
                    end
                end
            endcase
        end
    endfunction

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check(name, 64'(dut_outs()), 64'(m));
        if (bus.nco_we) begin
            if (last_we >= 0) check("wr_spacing", 64'(cyc - last_we >= G + 1), 64'd1);
            last_we = cyc;
        end
        if (m_mode == 0) last_we = -1;
    endtask

    task automatic go_run();
        bus.start = 1'b1;
        step("to_run");
        bus.start = 1'b0;
        for (int i = 0; i < 2*G + 3; i++) step("to_run");
    endtask

    vec_t tbl[10];
    int   ack_at;

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.stop = 0; bus.lf_valid = 0; bus.lf_data = '0;
        bus.host_req = 0; bus.host_sel = 0; bus.host_data = '0;
        m = '0; m_mode = 0; m_t = 0; m_full = 0; m_buf = '0;

        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, FI,            1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, FI,            1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, PI,            1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, PI,            1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, PI,            1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, PI,            1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h2000_1234, 1'b0, 1'b1, PI,            1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h2000_1234, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h2000_1234, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h2000_1234, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 4; i++) step("reset");
        check("reset_outs", 64'(dut_outs()), 64'd0);
        rst = 1'b0;
        step("idle");

        // Init sequence and single LF update
        foreach (tbl[i]) begin
            bus.start = tbl[i].start; bus.lf_valid = tbl[i].lfv; bus.lf_data = tbl[i].lfd;
            step("tbl_model");
            check($sformatf("tbl[%0d]", i),
                  {bus.nco_we, bus.nco_reg_sel, bus.nco_data, bus.nco_ce, bus.nco_sclr, bus.running},
                  {tbl[i].we, tbl[i].sel, tbl[i].data, tbl[i].ce, tbl[i].sclr, tbl[i].run});
        end
        bus.start = 0; bus.lf_valid = 0;
        check("lf_no_drop", 64'(bus.lf_drop_cnt), 64'd0);

        // Host and LF in the same cycle: host first, LF G+1 cycles later
        bus.host_req = 1; bus.host_sel = 1; bus.host_data = 32'hAAAA_0000;
        bus.lf_valid = 1; bus.lf_data = 32'h2000_5678;
        step("arb");
        bus.host_req = 0; bus.lf_valid = 0;
        check("arb_host", {bus.nco_we, bus.nco_reg_sel, bus.nco_data, bus.host_ack},
              {1'b1, 1'b1, 32'hAAAA_0000, 1'b1});
        step("arb_gap");
        check("arb_gap_we", 64'(bus.nco_we), 64'd0);
        step("arb_lf");
        check("arb_lf", {bus.nco_we, bus.nco_reg_sel, bus.nco_data, bus.host_ack},
              {1'b1, 1'b0, 32'h2000_5678, 1'b0});
        step("arb_tail");

        // Overrun: host keeps the port busy while three LF words arrive
        bus.host_req = 1; bus.host_sel = 0; bus.host_data = 32'h1111_0000;
        for (int i = 0; i < 3; i++) begin
            bus.lf_valid = 1; bus.lf_data = 32'h2000_0A00 + i;
            step("ovr");
        end
        bus.lf_valid = 0;
        step("ovr_hold");
        bus.host_req = 0;
        step("ovr_drain");
        check("ovr_last_word", {bus.nco_we, bus.nco_reg_sel, bus.nco_data, bus.lf_drop_cnt},
              {1'b1, 1'b0, 32'h2000_0A02, 16'd2});
        step("ovr_tail");

        // Abort in GAP_F, then replay with a host request held from the start
        bus.stop = 1; step("stop"); bus.stop = 0;
        bus.start = 1; step("ab_start"); bus.start = 0;
        step("ab_wrf");
        bus.stop = 1; step("abort"); bus.stop = 0;
        check("abort_idle", {bus.nco_we, bus.nco_ce, bus.running}, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step("abort_quiet");
            check("abort_no_wr", 64'(bus.nco_we), 64'd0);
        end
        bus.host_req = 1; bus.host_sel = 0; bus.host_data = 32'h3333_0000;
        bus.start = 1; step("replay"); bus.start = 0;
        ack_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step("replay");
            if (bus.host_ack) begin ack_at = k; break; end
        end
        bus.host_req = 0;
        check("host_held_off", 64'(ack_at), 64'(2*G + 4));
        step("replay_tail");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.start    = ($urandom_range(39) == 0);
            bus.stop     = ($urandom_range(59) == 0);
            rst          = ($urandom_range(499) == 0);
            bus.lf_valid = ($urandom_range(2) == 0);
            bus.lf_data  = $urandom;
            if (bus.host_req && (bus.host_ack || $urandom_range(19) == 0)) bus.host_req = 0;
            else if (!bus.host_req && $urandom_range(3) == 0) begin
                bus.host_req  = 1;
                bus.host_sel  = 1'($urandom_range(1));
                bus.host_data = $urandom;
            end
            step("rand");
        end
        bus.start = 0; bus.stop = 0; bus.lf_valid = 0; bus.host_req = 0;

        // Saturation: host owns every slot so each LF word after the first drops
        rst = 1; step("sat_rst"); rst = 0;
        go_run();
        bus.host_req = 1; bus.host_sel = 0; bus.host_data = 32'h5555_0000;
        bus.lf_valid = 1;
        for (int i = 0; i < 66000; i++) begin
            bus.lf_data = i;
            step("sat");
        end
        check("sat_drop", 64'(bus.lf_drop_cnt), 64'hFFFF);

        // Reset in the middle of RUN
        rst = 1; bus.host_req = 0; bus.lf_valid = 0;
        step("rst_run");
        check("rst_run_outs", 64'(dut_outs()), 64'd0);
        rst = 0;
        step("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
